// File: rtl/slt_arbiter_if.sv
// Request/response bundle for the shared set-less-than comparator.
// The master side is the requesters plus the result consumer; the slave side is the arbiter.
interface slt_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_rs;
  logic [16*NREQ-1:0] req_rt;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_lt;
  logic               busy;

  modport master (
    output req_valid, req_rs, req_rt, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_lt, busy
  );

  modport slave (
    input  req_valid, req_rs, req_rt, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_lt, busy
  );
endinterface

// File: rtl/slt_arbiter.sv
// Round-robin arbiter that shares one unsigned 16-bit set-less-than comparator
// among NREQ requesters. One operation is in flight at a time: IDLE -> CMP -> RESP.
module slt_16bit (
  input  logic [15:0] rs,
  input  logic [15:0] rt,
  output logic        lt
);
  assign lt = (rs < rt);
endmodule

module slt_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic          clk,
  input logic          rst_n,
  slt_arbiter_if.slave bus
);
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t            state;
  logic [IDW-1:0]    rr_ptr;
  logic [DATA_W-1:0] rs_p1;
  logic [DATA_W-1:0] rt_p1;
  logic [IDW-1:0]    id_p1;
  logic              found;
  logic [IDW-1:0]    win;
  logic              lt;

  // Scan from ptr upwards (mod NREQ); walking backwards lets the nearest hit win.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0] r;
    int           idx;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (v[idx]) r = {1'b1, idx[IDW-1:0]};
    end
    return r;
  endfunction

  always_comb begin
    {found, win}  = rr_pick(bus.req_valid, rr_ptr);
    bus.req_ready = '0;
    if (state == IDLE && found) bus.req_ready[win] = 1'b1;
  end

  // Stage p1: operands and owner captured at the grant edge.
  always_ff @(posedge clk) begin
    if (state == IDLE && found) begin
      rs_p1 <= bus.req_rs[DATA_W*win +: DATA_W];
      rt_p1 <= bus.req_rt[DATA_W*win +: DATA_W];
      id_p1 <= win;
    end
  end

  slt_16bit u_slt (
    .rs (rs_p1),
    .rt (rt_p1),
    .lt (lt)
  );

  // Stage p2: registered result held on the response channel until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_lt    <= '0;
      bus.busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state    <= CMP;
            bus.busy <= 1'b1;
          end
        end
        CMP: begin
          bus.rsp_lt    <= {{(DATA_W-1){1'b0}}, lt};
          bus.rsp_id    <= id_p1;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            rr_ptr        <= (id_p1 == IDW'(NREQ - 1)) ? '0 : id_p1 + IDW'(1);
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_slt_arbiter.sv
// Scoreboard bench for slt_arbiter: a transaction-level server model predicts grants
// and results, a separate monitor checks every response presented on the channel.
module tb_slt_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slt_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  slt_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int          id;
    logic [15:0] lt;
    int          acc;
  } exp_t;

  exp_t        expq[$];
  int          done_id[$];
  logic [15:0] done_lt[$];
  int          done_cyc[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          rst_edge = 1'b1;
  bit          free = 1'b1;
  int          ptr = 0;
  bit          rel_pending = 1'b0;
  int          rel_ptr = 0;
  bit          prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_edge = !rst_n;
  end

  // Reference model: one server, round-robin pointer advanced only on completion.
  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int              w;
    if (rst_edge) begin
      expq.delete();
      free = 1'b1;
      ptr = 0;
      rel_pending = 1'b0;
    end else if (rel_pending) begin
      free = 1'b1;
      ptr = rel_ptr;
      rel_pending = 1'b0;
    end
    er = '0;
    w = -1;
    if (free)
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && bus.req_valid[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", bus.req_ready, er);
    chk("busy", bus.busy, !free);
    if (w >= 0 && rst_n) begin
      expq.push_back('{w, (bus.req_rs[16*w +: 16] < bus.req_rt[16*w +: 16]) ? 16'h0001 : 16'h0000, cyc});
      free = 1'b0;
    end
  end

  // Monitor: every presented response must match the oldest outstanding prediction.
  always @(negedge clk) begin
    #1;
    if (rst_edge) begin
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_lt", bus.rsp_lt, 0);
    end else if (bus.rsp_valid) begin
      if (expq.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        chk("rsp_id", bus.rsp_id, expq[0].id);
        chk("rsp_lt", bus.rsp_lt, expq[0].lt);
        if (!prev_valid) chk("rsp_latency", cyc, expq[0].acc + 2);
        if (bus.rsp_ready && rst_n) begin
          done_id.push_back(expq[0].id);
          done_lt.push_back(bus.rsp_lt);
          done_cyc.push_back(cyc);
          rel_ptr = (expq[0].id + 1) % NREQ;
          rel_pending = 1'b1;
          expq.pop_front();
        end
      end
    end else if (expq.size() > 0 && cyc >= expq[0].acc + 2) begin
      chk("rsp_missing", 0, 1);
    end
    prev_valid = bus.rsp_valid && !(bus.rsp_ready && rst_n);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid[i] = v;
    bus.req_rs[16*i +: 16] = a;
    bus.req_rt[16*i +: 16] = b;
  endtask

  task automatic wait_grant(input int i, input string nm);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) break;
    end
    if (k == 20) chk({nm, "_grant_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input int n0, input string nm);
    for (int k = 0; k < 30 && done_lt.size() <= n0; k++) tick();
    if (done_lt.size() <= n0) chk({nm, "_done_timeout"}, 0, 1);
  endtask

  task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_lt, input string nm);
    int n0;
    n0 = done_lt.size();
    set_req(i, 1'b1, a, b);
    bus.rsp_ready = 1'b1;
    wait_grant(i, nm);
    tick();
    bus.req_valid[i] = 1'b0;
    wait_done(n0, nm);
    if (done_lt.size() > n0) chk(nm, done_lt[$], exp_lt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    int k;
    logic [15:0] hold_lt;
    logic [IDW-1:0] hold_id;
    int order[5];
    logic [15:0] ext[4];
    order = '{0, 1, 2, 3, 0};
    ext = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    bus.req_valid = '0;
    bus.req_rs = '0;
    bus.req_rt = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Single requester, then the boundary operand pairs.
    do_op(0, 16'h0003, 16'h0005, 16'h0001, "t2_lt");
    if (done_id.size() > 0) chk("t2_id", done_id[$], 0);
    do_op(1, 16'h1234, 16'h1234, 16'h0000, "t3_equal");
    do_op(2, 16'hFFFF, 16'h0000, 16'h0000, "t3_ffff_0");
    do_op(3, 16'h0000, 16'hFFFF, 16'h0001, "t3_0_ffff");
    do_op(0, 16'h7FFF, 16'h8000, 16'h0001, "t3_7fff_8000");

    // Wrap-around: serve req3 (pointer -> 0), then lone req2, then req2+req3.
    do_op(3, 16'h0010, 16'h0001, 16'h0000, "t6_req3");
    do_op(2, 16'h0001, 16'h0010, 16'h0001, "t6_req2");
    if (done_id.size() > 0) chk("t6_wrap_id", done_id[$], 2);
    n0 = done_lt.size();
    set_req(2, 1'b1, 16'h0002, 16'h0003);
    set_req(3, 1'b1, 16'h0004, 16'h0003);
    @(negedge clk);
    chk("t6_req3_first", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = '0;
    wait_done(n0, "t6_pair");
    if (done_id.size() > n0) chk("t6_pair_id", done_id[$], 3);

    // Back-pressure: response must hold while the consumer stalls.
    set_req(1, 1'b1, 16'h0005, 16'h0004);
    bus.rsp_ready = 1'b0;
    wait_grant(1, "t5");
    tick();
    bus.req_valid = 4'b1101;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    if (k == 10) chk("t5_valid_timeout", 0, 1);
    hold_id = bus.rsp_id;
    hold_lt = bus.rsp_lt;
    chk("t5_id", hold_id, 1);
    for (int j = 0; j < 5; j++) begin
      tick();
      #2;
      chk("t5_hold_valid", bus.rsp_valid, 1);
      chk("t5_hold_id", bus.rsp_id, hold_id);
      chk("t5_hold_lt", bus.rsp_lt, hold_lt);
      chk("t5_hold_ready", bus.req_ready, 0);
      chk("t5_hold_busy", bus.busy, 1);
    end
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("t5_release", bus.rsp_valid, 0);
    repeat (2) tick();

    // Reset while a result waits in RESP: it is discarded and the pointer returns to 0.
    set_req(0, 1'b1, 16'h0001, 16'h0002);
    bus.rsp_ready = 1'b0;
    wait_grant(0, "t1");
    tick();
    bus.req_valid = '0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    if (k == 10) chk("t1_valid_timeout", 0, 1);
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    chk("t1_rsp_valid", bus.rsp_valid, 0);
    chk("t1_busy", bus.busy, 0);
    chk("t1_rsp_lt", bus.rsp_lt, 0);
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'(i), 16'h0002);
    @(negedge clk);
    chk("t1_first_grant", bus.req_ready, 4'b0001);

    // All requesters valid continuously: strict rotation, one result per 3 cycles.
    tick();
    bus.rsp_ready = 1'b1;
    n0 = done_id.size();
    for (k = 0; k < 40 && done_id.size() < n0 + 5; k++) tick();
    if (done_id.size() < n0 + 5) chk("t4_timeout", 0, 1);
    else begin
      for (int j = 0; j < 5; j++) chk("t4_order", done_id[n0 + j], order[j]);
      for (int j = 1; j < 5; j++) chk("t4_spacing", done_cyc[n0 + j] - done_cyc[n0 + j - 1], 3);
    end
    bus.req_valid = '0;
    repeat (6) tick();

    // Random traffic with occasional resets and consumer stalls.
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      bus.req_valid = rst_n ? NREQ'($urandom) : '0;
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 2))
          0: begin
            bus.req_rs[16*i +: 16] = 16'($urandom);
            bus.req_rt[16*i +: 16] = bus.req_rs[16*i +: 16];
          end
          1: begin
            bus.req_rs[16*i +: 16] = 16'($urandom);
            bus.req_rt[16*i +: 16] = 16'($urandom);
          end
          default: begin
            bus.req_rs[16*i +: 16] = ext[$urandom_range(0, 3)];
            bus.req_rt[16*i +: 16] = ext[$urandom_range(0, 3)];
          end
        endcase
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    rst_n = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (10) tick();
    chk("drain_empty", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
